// File: rtl/prime_checker_param_if.sv
// Handshake bundle for the prime checker: a controller drives start/num/abort
// and the checker returns busy/done plus the result pair.
interface prime_checker_param_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] num;
  logic             abort;
  logic             busy;
  logic             done;
  logic             is_prime;
  logic [WIDTH-1:0] factor;

  modport master (output start, num, abort, input busy, done, is_prime, factor);
  modport slave  (input start, num, abort, output busy, done, is_prime, factor);
endinterface

// File: rtl/prime_checker_param.sv
// Primality test by odd-only trial division; each remainder is produced by a
// WIDTH-cycle restoring shift-subtract divider. Reports smallest prime factor.
module prime_checker_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prime_checker_param_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SQ_W  = 2 * WIDTH + 4;

  typedef enum logic [1:0] {IDLE, PRE, DIV, EVAL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH:0]   d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_prime_q, is_prime_d;
  logic [WIDTH-1:0] factor_q, factor_d;

  logic             accept;
  logic             pre_special;
  logic             div_last;
  logic             n_bit;
  logic [WIDTH:0]   r_shift;
  logic             r_zero;
  logic             sq_over;

  // (d+2)^2 > n, computed wide enough that the square cannot wrap
  function automatic logic square_exceeds(input logic [WIDTH:0] d, input logic [WIDTH-1:0] n);
    logic [SQ_W-1:0] dp2;
    dp2 = SQ_W'(d) + SQ_W'(2);
    return (dp2 * dp2) > SQ_W'(n);
  endfunction

  assign accept      = bus.start && !bus.abort;
  assign pre_special = (n_q < WIDTH'(4)) || !n_q[0];
  assign div_last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign n_bit       = |(n_q & (WIDTH'(1) << (CNT_W'(WIDTH - 1) - cnt_q)));
  assign r_shift     = {r_q[WIDTH-1:0], n_bit};
  assign r_zero      = (r_q == '0);
  assign sq_over     = square_exceeds(d_q, n_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      is_prime_q <= 1'b0;
      factor_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      is_prime_q <= is_prime_d;
      factor_q   <= factor_d;
    end
  end

  always_ff @(posedge clk) begin
    n_q <= n_d;
    d_q <= d_d;
    r_q <= r_d;
  end

  // abort outranks any terminal decision taken in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = PRE;
      PRE:  if (bus.abort || pre_special) state_d = IDLE;
            else state_d = DIV;
      DIV:  if (bus.abort) state_d = IDLE;
            else if (div_last) state_d = EVAL;
      EVAL: if (bus.abort || r_zero || sq_over) state_d = IDLE;
            else state_d = DIV;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_d        = n_q;
    d_d        = d_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    is_prime_d = is_prime_q;
    factor_d   = factor_q;
    unique case (state_q)
      IDLE: if (accept) n_d = bus.num;
      PRE: begin
        if (!bus.abort) begin
          if (n_q < WIDTH'(2)) begin
            done_d     = 1'b1;
            is_prime_d = 1'b0;
            factor_d   = '0;
          end else if (n_q < WIDTH'(4)) begin
            done_d     = 1'b1;
            is_prime_d = 1'b1;
            factor_d   = n_q;
          end else if (!n_q[0]) begin
            done_d     = 1'b1;
            is_prime_d = 1'b0;
            factor_d   = WIDTH'(2);
          end else begin
            d_d   = (WIDTH + 1)'(3);
            r_d   = '0;
            cnt_d = '0;
          end
        end
      end
      DIV: begin
        r_d   = (r_shift >= d_q) ? (r_shift - d_q) : r_shift;
        cnt_d = cnt_q + CNT_W'(1);
      end
      EVAL: begin
        if (!bus.abort) begin
          if (r_zero) begin
            done_d     = 1'b1;
            is_prime_d = 1'b0;
            factor_d   = d_q[WIDTH-1:0];
          end else if (sq_over) begin
            done_d     = 1'b1;
            is_prime_d = 1'b1;
            factor_d   = n_q;
          end else begin
            d_d   = d_q + (WIDTH + 1)'(2);
            r_d   = '0;
            cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.is_prime = is_prime_q;
  assign bus.factor   = factor_q;
endmodule

// File: tb/tb_prime_checker_param.sv
// Directed and randomised check of prime_checker_param (WIDTH=16) against a
// trial-division reference model.
module tb_prime_checker_param;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;
  bit   chained;

  prime_checker_param_if #(.WIDTH(W)) bus();

  prime_checker_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Smallest prime factor and cycle count straight from the algorithm's rules.
  function automatic void ref_model(input int unsigned n, output bit prime,
                                    output int unsigned fac, output int lat);
    longint unsigned d;
    int k;
    lat = 1;
    if (n < 2) begin
      prime = 0; fac = 0;
    end else if (n == 2 || n == 3) begin
      prime = 1; fac = n;
    end else if (n % 2 == 0) begin
      prime = 0; fac = 2;
    end else begin
      prime = 1; fac = n; d = 3; k = 0;
      while (1) begin
        k++;
        if (n % d == 0) begin
          prime = 0; fac = int'(d); break;
        end
        if ((d + 2) * (d + 2) > n) break;
        d += 2;
      end
      lat = 1 + k * (W + 1);
    end
  endfunction

  // chain_next: on done, immediately present the next start (back-to-back)
  task automatic run_op(input string tag, input int unsigned v, input bit exp_p,
                        input int unsigned exp_f, input int exp_lat, input int poke,
                        input bit chain_next, input int unsigned next_v);
    int lat;
    int busy_hi;
    bit seen;
    if (!chained) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.num   = W'(v);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chained   = 1'b0;
    busy_hi   = bus.busy ? 1 : 0;
    lat = 0;
    seen = 0;
    while (lat < 3000) begin
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.num   = W'(9);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) busy_hi++;
    end
    bus.start = 1'b0;
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " is_prime"}, bus.is_prime, exp_p);
    chk({tag, " factor"}, bus.factor, exp_f);
    chk({tag, " busy_cycles"}, busy_hi, exp_lat);
    chk({tag, " busy_at_done"}, bus.busy, 0);
    if (chain_next) begin
      bus.start = 1'b1;
      bus.num   = W'(next_v);
      chained   = 1'b1;
    end
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) hits++;
    end
    chk({tag, " no_done"}, hits, 0);
  endtask

  initial begin
    bit p;
    int unsigned f;
    int l;
    int unsigned v;
    tests = 0; failures = 0; chained = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.num = '0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst is_prime", bus.is_prime, 0);
    chk("rst factor", bus.factor, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("n7", 7, 1, 7, 18, -1, 0, 0);
    run_op("n15", 15, 0, 3, 18, -1, 0, 0);
    run_op("n25_ignored_start", 25, 0, 5, 35, 5, 0, 0);

    // Abort partway through a long run; prior result (0,5) must survive.
    @(negedge clk); bus.start = 1'b1; bus.num = W'(65521);
    @(posedge clk); #1; bus.start = 1'b0;
    no_done_for("abort pre", 100);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort is_prime", bus.is_prime, 0);
    chk("abort factor", bus.factor, 5);
    no_done_for("abort post", 20);

    run_op("n63001", 63001, 0, 251, 2126, -1, 0, 0);
    run_op("n0", 0, 0, 0, 1, -1, 0, 0);
    run_op("n1", 1, 0, 0, 1, -1, 0, 0);
    run_op("n2", 2, 1, 2, 1, -1, 0, 0);
    run_op("n1024", 1024, 0, 2, 1, -1, 0, 0);
    run_op("n65521", 65521, 1, 65521, 2160, -1, 0, 0);

    // Asynchronous reset in the middle of a division.
    @(negedge clk); bus.start = 1'b1; bus.num = W'(65521);
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    chk("midrst is_prime", bus.is_prime, 0);
    chk("midrst factor", bus.factor, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    no_done_for("midrst post", 20);

    run_op("n9", 9, 0, 3, 18, -1, 1, 13);
    run_op("n13_b2b", 13, 1, 13, 18, -1, 0, 0);

    for (int i = 0; i < 14; i++) begin
      v = (i < 7) ? $urandom_range(0, 3000) : $urandom_range(0, 65535);
      ref_model(v, p, f, l);
      run_op($sformatf("rand%0d_n%0d", i, v), v, p, f, l, -1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
